sprite_plot_scheduler: RTL and testbench

Frame-driven scheduler that shares the single VGA adapter plot port (x, y, colour, plot) between NUM_SLOTS sprite drawers (birds, hunter). On each frame tick it walks the slots in index order. For each slot it runs an erase pass (colour 0) at the previously drawn position, then a draw pass in the slot colour. It muxes the active drawer's pixel stream onto the plot port. It sits between the sprite drawer instances and vga_adapter, and replaces ad-hoc per-sprite erase/draw FSMs in the top level.

---
 rtl/sprite_plot_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plot_scheduler.sv
// Frame-driven scheduler that shares the single VGA plot port between sprite drawers,
// erasing each slot at its old position and then redrawing it in the slot colour.
module sprite_plot_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          frame_tick,
  input  logic [NUM_SLOTS-1:0]          slot_en,
  input  logic [NUM_SLOTS*COLOUR_W-1:0] slot_colour,
  output logic [NUM_SLOTS-1:0]          start,
  output logic                          erase,
  input  logic [NUM_SLOTS*X_W-1:0]      pix_x,
  input  logic [NUM_SLOTS*Y_W-1:0]      pix_y,
  input  logic [NUM_SLOTS-1:0]          pix_valid,
  input  logic [NUM_SLOTS-1:0]          done,
  output logic [X_W-1:0]                x,
  output logic [Y_W-1:0]                y,
  output logic [COLOUR_W-1:0]           colour,
  output logic                          plot,
  output logic                          busy,
  output logic                          overrun,
  output logic [NUM_SLOTS-1:0]          fault
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    E_START,
    E_WAIT,
    D_START,
    D_WAIT
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [NUM_SLOTS-1:0] drawn_mask;
  logic [NUM_SLOTS-1:0] en_l;
  logic [TMR_W-1:0]     timer;

  logic                 sel_valid;
  logic                 sel_done;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOUR_W-1:0]  sel_colour;
  logic [NUM_SLOTS-1:0] idx_onehot;
  logic                 last_slot;
  logic                 done_seen;
  logic                 hit_limit;
  logic                 pass_end;
  logic                 timed_out;

  // The first wait cycle ignores done: the drawer may still hold it from its last pass.
  always_comb begin
    sel_valid       = pix_valid[idx];
    sel_done        = done[idx];
    sel_x           = pix_x[idx*X_W +: X_W];
    sel_y           = pix_y[idx*Y_W +: Y_W];
    sel_colour      = slot_colour[idx*COLOUR_W +: COLOUR_W];
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
    last_slot       = (idx == IDX_W'(NUM_SLOTS - 1));
    done_seen       = (timer != '0) && sel_done;
    hit_limit       = (timer == TMR_W'(TIMEOUT - 1));
    pass_end        = done_seen || hit_limit;
    timed_out       = hit_limit && !done_seen;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= '0;
      start      <= '0;
      erase      <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      fault      <= '0;
      drawn_mask <= '0;
      en_l       <= '0;
      timer      <= '0;
    end else begin
      start <= '0;
      plot  <= 1'b0;
      if (frame_tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_tick) begin
            en_l  <= slot_en;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (drawn_mask[idx]) begin
            start <= idx_onehot;
            erase <= 1'b1;
            state <= E_START;
          end else if (en_l[idx]) begin
            start <= idx_onehot;
            state <= D_START;
          end else begin
            state <= last_slot ? IDLE : SCAN;
            idx   <= last_slot ? idx : idx + IDX_W'(1);
            busy  <= !last_slot;
          end
        end

        E_START: begin
          timer <= '0;
          state <= E_WAIT;
        end

        D_START: begin
          timer <= '0;
          state <= D_WAIT;
        end

        E_WAIT: begin
          plot   <= sel_valid;
          x      <= sel_x;
          y      <= sel_y;
          colour <= '0;
          timer  <= timer + TMR_W'(1);
          if (pass_end) begin
            if (timed_out) begin
              fault[idx] <= 1'b1;
            end
            drawn_mask[idx] <= 1'b0;
            erase           <= 1'b0;
            if (en_l[idx]) begin
              start <= idx_onehot;
              state <= D_START;
            end else begin
              state <= last_slot ? IDLE : SCAN;
              idx   <= last_slot ? idx : idx + IDX_W'(1);
              busy  <= !last_slot;
            end
          end
        end

        D_WAIT: begin
          plot   <= sel_valid;
          x      <= sel_x;
          y      <= sel_y;
          colour <= sel_colour;
          timer  <= timer + TMR_W'(1);
          // A timed-out draw still counts as drawn so the next frame erases it.
          if (pass_end) begin
            if (timed_out) begin
              fault[idx] <= 1'b1;
            end
            drawn_mask[idx] <= 1'b1;
            state           <= last_slot ? IDLE : SCAN;
            idx             <= last_slot ? idx : idx + IDX_W'(1);
            busy            <= !last_slot;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Self-checking bench: behavioural drawers plus a frame-timeline model predicting every
// cycle of the scheduler's outputs.
module tb_sprite_plot_scheduler;

  localparam int NS  = 2;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int CW  = 3;
  localparam int TO  = 64;
  localparam int NC  = 2048;
  localparam int INF = 1 << 30;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             frame_tick = 1'b0;
  logic [NS-1:0]    slot_en = '0;
  logic [NS*CW-1:0] slot_colour = {3'b010, 3'b111};
  logic [NS-1:0]    start;
  logic             erase;
  logic [NS*XW-1:0] pix_x = '0;
  logic [NS*YW-1:0] pix_y = '0;
  logic [NS-1:0]    pix_valid = '0;
  logic [NS-1:0]    done = '0;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [CW-1:0]    colour;
  logic             plot;
  logic             busy;
  logic             overrun;
  logic [NS-1:0]    fault;

  sprite_plot_scheduler #(
    .NUM_SLOTS(NS), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .slot_en(slot_en),
    .slot_colour(slot_colour), .start(start), .erase(erase), .pix_x(pix_x),
    .pix_y(pix_y), .pix_valid(pix_valid), .done(done), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .overrun(overrun), .fault(fault)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Drawer behaviour per slot and pass (index 0 = draw, 1 = erase)
  int cfg_npix [NS][2];
  bit cfg_hang [NS][2];
  bit noise = 1'b0;

  // Expected per-cycle timeline
  logic [NS-1:0] e_start [NC];
  bit            e_erase [NC];
  bit            e_plot  [NC];
  bit            e_busy  [NC];
  logic [XW-1:0] e_x     [NC];
  logic [YW-1:0] e_y     [NC];
  logic [CW-1:0] e_col   [NC];
  logic [NS-1:0] m_drawn = '0;
  int            ovr_from = INF;
  int            f_from [NS];
  int            last_dwait = 0;

  int cnt_start = 0, cnt_plot = 0, cnt_erase = 0, cnt_busy = 0;
  int d_start, d_plot, d_erase, d_busy;

  function automatic logic [XW-1:0] px(input int i, input bit er, input int j);
    return XW'(40 * i + 20 * int'(er) + j + 3);
  endfunction

  function automatic logic [YW-1:0] py(input int i, input bit er, input int j);
    return YW'(10 * i + 5 * int'(er) + j + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // One pass starting (start pulse) at cycle s; returns the cycle after its last wait cycle.
  task automatic plan_pass(input int s, input int i, input bit er, output int nxt);
    int np, w;
    np = cfg_npix[i][er];
    w  = cfg_hang[i][er] ? TO : np;
    e_start[s]    = '0;
    e_start[s][i] = 1'b1;
    for (int c = s; c <= s + w; c++) e_erase[c] = er;
    for (int j = 0; j < np && j < w; j++) begin
      e_plot[s + 2 + j] = 1'b1;
      e_x[s + 2 + j]    = px(i, er, j);
      e_y[s + 2 + j]    = py(i, er, j);
      e_col[s + 2 + j]  = er ? '0 : slot_colour[i*CW +: CW];
    end
    if (cfg_hang[i][er] && (s + 1 + w < f_from[i])) f_from[i] = s + 1 + w;
    nxt = s + 1 + w;
  endtask

  // Tick sampled at the end of cycle t0; returns the first idle cycle after the frame.
  task automatic plan_frame(input int t0, input logic [NS-1:0] en, output int fend);
    int c;
    c = t0 + 1;
    for (int i = 0; i < NS; i++) begin
      c = c + 1;
      if (m_drawn[i]) begin
        plan_pass(c, i, 1'b1, c);
        m_drawn[i] = 1'b0;
      end
      if (en[i]) begin
        last_dwait = c + 1;
        plan_pass(c, i, 1'b0, c);
        m_drawn[i] = 1'b1;
      end
    end
    for (int k = t0 + 1; k < c; k++) e_busy[k] = 1'b1;
    fend = c;
  endtask

  task automatic model_reset(input int from);
    for (int k = from; k < NC; k++) begin
      e_start[k] = '0; e_erase[k] = 1'b0; e_plot[k] = 1'b0; e_busy[k] = 1'b0;
    end
    m_drawn  = '0;
    ovr_from = INF;
    for (int i = 0; i < NS; i++) f_from[i] = INF;
  endtask

  // Run one frame, optionally with two extra ticks while busy; records event-count deltas.
  task automatic applyStimulus(input logic [NS-1:0] en, input int ovr_off);
    int b_s, b_p, b_e, b_b, t0, fend;
    @(negedge clock);
    b_s = cnt_start; b_p = cnt_plot; b_e = cnt_erase; b_b = cnt_busy;
    frame_tick = 1'b1;
    slot_en    = en;
    t0         = cyc;
    plan_frame(t0, en, fend);
    @(negedge clock);
    frame_tick = 1'b0;
    slot_en    = ~en;
    while (cyc < fend + 1) begin
      @(negedge clock);
      if (ovr_off != 0 && (cyc == t0 + ovr_off || cyc == t0 + ovr_off + 5)) begin
        frame_tick = 1'b1;
        if (t0 + ovr_off + 1 < ovr_from) ovr_from = t0 + ovr_off + 1;
      end else begin
        frame_tick = 1'b0;
      end
    end
    frame_tick = 1'b0;
    d_start = cnt_start - b_s;
    d_plot  = cnt_plot - b_p;
    d_erase = cnt_erase - b_e;
    d_busy  = cnt_busy - b_b;
  endtask

  // Behavioural drawers: stale done held until the second cycle of the next pass.
  initial begin
    int  dk [NS];
    bit  dact [NS];
    bit  der [NS];
    for (int i = 0; i < NS; i++) begin dk[i] = 0; dact[i] = 1'b0; der[i] = 1'b0; end
    forever begin
      @(negedge clock);
      for (int i = 0; i < NS; i++) begin
        if (!resetn) begin
          dact[i] = 1'b0; dk[i] = 0; done[i] = 1'b0; pix_valid[i] = 1'b0;
        end else if (start[i]) begin
          dact[i] = 1'b1; dk[i] = 0; der[i] = erase; pix_valid[i] = 1'b0;
        end else if (dact[i]) begin
          dk[i] = dk[i] + 1;
          if (dk[i] == 2) done[i] = 1'b0;
          if (dk[i] >= 1 && dk[i] <= cfg_npix[i][der[i]]) begin
            pix_valid[i]       = 1'b1;
            pix_x[i*XW +: XW]  = px(i, der[i], dk[i] - 1);
            pix_y[i*YW +: YW]  = py(i, der[i], dk[i] - 1);
          end else begin
            pix_valid[i] = 1'b0;
          end
          if (!cfg_hang[i][der[i]] && dk[i] == cfg_npix[i][der[i]]) done[i] = 1'b1;
          if (!cfg_hang[i][der[i]] && dk[i] > cfg_npix[i][der[i]]) dact[i] = 1'b0;
        end else begin
          pix_valid[i]      = noise;
          pix_x[i*XW +: XW] = 8'hEE;
          pix_y[i*YW +: YW] = 7'h7E;
        end
      end
    end
  end

  // Compare process
  initial begin
    logic [NS-1:0] ef;
    forever begin
      @(negedge clock);
      if (chk_en && cyc < NC) begin
        for (int i = 0; i < NS; i++) ef[i] = (cyc >= f_from[i]);
        checkOutput("start", 32'(start), 32'(e_start[cyc]));
        checkOutput("erase", 32'(erase), 32'(e_erase[cyc]));
        checkOutput("plot", 32'(plot), 32'(e_plot[cyc]));
        checkOutput("busy", 32'(busy), 32'(e_busy[cyc]));
        checkOutput("overrun", 32'(overrun), 32'(cyc >= ovr_from));
        checkOutput("fault", 32'(fault), 32'(ef));
        if (e_plot[cyc]) begin
          checkOutput("x", 32'(x), 32'(e_x[cyc]));
          checkOutput("y", 32'(y), 32'(e_y[cyc]));
          checkOutput("colour", 32'(colour), 32'(e_col[cyc]));
        end
        if (|start) cnt_start = cnt_start + 1;
        if (plot)   cnt_plot  = cnt_plot + 1;
        if (erase)  cnt_erase = cnt_erase + 1;
        if (busy)   cnt_busy  = cnt_busy + 1;
      end
    end
  end

  initial begin
    int t0, fend, r;
    for (int k = 0; k < NC; k++) begin
      e_start[k] = '0; e_erase[k] = 1'b0; e_plot[k] = 1'b0; e_busy[k] = 1'b0;
      e_x[k] = '0; e_y[k] = '0; e_col[k] = '0;
    end
    for (int i = 0; i < NS; i++) begin
      f_from[i] = INF;
      cfg_npix[i][0] = 3; cfg_npix[i][1] = 3;
      cfg_hang[i][0] = 1'b0; cfg_hang[i][1] = 1'b0;
    end

    repeat (3) @(negedge clock);
    resetn = 1'b1;
    chk_en = 1'b1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_start", 32'(start), 32'd0);
    checkOutput("reset_plot", 32'(plot), 32'd0);
    checkOutput("reset_xyc", {8'd0, x, 1'b0, y, 5'd0, colour}, 32'd0);
    checkOutput("reset_flags", {overrun, fault}, 32'd0);

    $display("[TB] frame A: draw slot 0");
    applyStimulus(2'b01, 0);
    checkOutput("A_starts", d_start, 1);
    checkOutput("A_plots", d_plot, 3);
    checkOutput("A_busy", d_busy, 6);
    checkOutput("A_erase", d_erase, 0);

    $display("[TB] frame B: erase slot 0 only");
    applyStimulus(2'b00, 0);
    checkOutput("B_starts", d_start, 1);
    checkOutput("B_plots", d_plot, 3);
    checkOutput("B_erase", d_erase, 4);
    checkOutput("B_busy", d_busy, 6);

    $display("[TB] frame C1: draw both slots");
    cfg_npix[1][0] = 2; cfg_npix[0][1] = 2; cfg_npix[1][1] = 2;
    applyStimulus(2'b11, 0);
    checkOutput("C1_starts", d_start, 2);
    checkOutput("C1_plots", d_plot, 5);
    checkOutput("C1_busy", d_busy, 9);

    $display("[TB] frame C2: erase+draw both, idle drawers chatter");
    noise = 1'b1;
    applyStimulus(2'b11, 0);
    checkOutput("C2_starts", d_start, 4);
    checkOutput("C2_plots", d_plot, 9);
    checkOutput("C2_erase", d_erase, 6);
    checkOutput("C2_busy", d_busy, 15);

    $display("[TB] frame D: drawer 1 never finishes its draw");
    cfg_hang[1][0] = 1'b1;
    applyStimulus(2'b11, 0);
    checkOutput("D_starts", d_start, 4);
    checkOutput("D_plots", d_plot, 9);
    checkOutput("D_busy", d_busy, 77);
    checkOutput("D_fault", 32'(fault), 32'd2);
    cfg_hang[1][0] = 1'b0;

    $display("[TB] frame E: ticks while busy");
    applyStimulus(2'b11, 3);
    checkOutput("E_starts", d_start, 4);
    checkOutput("E_busy", d_busy, 15);
    checkOutput("E_overrun", 32'(overrun), 32'd1);

    $display("[TB] frame F: tick after idle, erase both");
    applyStimulus(2'b00, 0);
    checkOutput("F_starts", d_start, 2);
    checkOutput("F_plots", d_plot, 4);
    checkOutput("F_busy", d_busy, 8);

    $display("[TB] frame G: reset during a draw wait");
    cfg_npix[0][0] = 10;
    @(negedge clock);
    frame_tick = 1'b1;
    slot_en    = 2'b01;
    t0         = cyc;
    plan_frame(t0, 2'b01, fend);
    @(negedge clock);
    frame_tick = 1'b0;
    r = last_dwait + 3;
    while (cyc < r) @(negedge clock);
    resetn = 1'b0;
    model_reset(r + 1);
    @(negedge clock);
    checkOutput("G_plot", 32'(plot), 32'd0);
    checkOutput("G_start", 32'(start), 32'd0);
    checkOutput("G_busy", 32'(busy), 32'd0);
    checkOutput("G_flags", {overrun, fault}, 32'd0);
    checkOutput("G_xyc", {8'd0, x, 1'b0, y, 5'd0, colour}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] frame H: normal draw after reset");
    cfg_npix[0][0] = 3;
    applyStimulus(2'b01, 0);
    checkOutput("H_starts", d_start, 1);
    checkOutput("H_plots", d_plot, 3);
    checkOutput("H_busy", d_busy, 6);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
